// File: rtl/cfg_stream_loader_if.sv
// Serial configuration input plus the committed configuration word and status flags.
interface cfg_stream_loader_if #(
  parameter int NUM_CLUSTERS = 8,
  parameter int CFG_BITS     = 16
);
  localparam int TOTAL = NUM_CLUSTERS * CFG_BITS;

  logic             config_en;
  logic             config_in;
  logic [TOTAL-1:0] cfg_out;
  logic             cfg_load;
  logic             cfg_done;
  logic             cfg_error;
  logic             busy;

  modport master (
    output config_en, config_in,
    input  cfg_out, cfg_load, cfg_done, cfg_error, busy
  );

  modport slave (
    input  config_en, config_in,
    output cfg_out, cfg_load, cfg_done, cfg_error, busy
  );
endinterface

// File: rtl/cfg_stream_loader.sv
// Deserializes a sync-framed, even-parity bitstream into the cluster configuration word.
// The live configuration is only replaced once a whole frame passes its parity check.
module cfg_stream_loader #(
  parameter int         NUM_CLUSTERS = 8,
  parameter int         CFG_BITS     = 16,
  parameter logic [7:0] SYNC_WORD    = 8'hA5
) (
  input logic               clk,
  input logic               rst,
  cfg_stream_loader_if.slave bus
);
  localparam int            TOTAL = NUM_CLUSTERS * CFG_BITS;
  localparam int            CW    = $clog2(TOTAL) + 1;
  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);

  typedef enum logic [1:0] {ST_HUNT, ST_LOAD, ST_PARITY} state_t;

  state_t             r_state;
  logic [7:0]         r_window;
  logic [TOTAL-1:0]   r_shadow;
  logic [CW-1:0]      r_count;
  logic               r_parity;
  logic [TOTAL-1:0]   r_cfg_out;
  logic               r_load;
  logic               r_done;
  logic               r_error;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [7:0]         w_window_nxt;
  logic [7:0]         w_win_shift;
  logic [TOTAL-1:0]   w_shadow_nxt;
  logic [CW-1:0]      w_count_nxt;
  logic               w_parity_nxt;
  logic [TOTAL-1:0]   w_cfg_out_nxt;
  logic               w_load_nxt;
  logic               w_done_nxt;
  logic               w_error_nxt;
  logic               w_busy_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_HUNT;
      r_window  <= '0;
      r_shadow  <= '0;
      r_count   <= '0;
      r_parity  <= 1'b0;
      r_cfg_out <= '0;
      r_load    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_window  <= w_window_nxt;
      r_shadow  <= w_shadow_nxt;
      r_count   <= w_count_nxt;
      r_parity  <= w_parity_nxt;
      r_cfg_out <= w_cfg_out_nxt;
      r_load    <= w_load_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_window_nxt  = r_window;
    w_win_shift   = {r_window[6:0], bus.config_in};
    w_shadow_nxt  = r_shadow;
    w_count_nxt   = r_count;
    w_parity_nxt  = r_parity;
    w_cfg_out_nxt = r_cfg_out;
    w_load_nxt    = 1'b0;
    w_done_nxt    = r_done;
    w_error_nxt   = r_error;

    if (bus.config_en) begin
      case (r_state)
        ST_HUNT: begin
          w_window_nxt = w_win_shift;
          if (w_win_shift == SYNC_WORD) begin
            w_state_nxt  = ST_LOAD;
            w_count_nxt  = '0;
            w_parity_nxt = 1'b0;
            w_done_nxt   = 1'b0;
            w_error_nxt  = 1'b0;
          end
        end
        ST_LOAD: begin
          // First payload bit ends up in the MSB after TOTAL shifts.
          w_shadow_nxt = {r_shadow[TOTAL-2:0], bus.config_in};
          w_parity_nxt = r_parity ^ bus.config_in;
          w_count_nxt  = r_count + 1'b1;
          if (r_count == LAST) w_state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          if ((r_parity ^ bus.config_in) == 1'b0) begin
            w_cfg_out_nxt = r_shadow;
            w_load_nxt    = 1'b1;
            w_done_nxt    = 1'b1;
          end else begin
            w_error_nxt = 1'b1;
          end
          w_state_nxt  = ST_HUNT;
          w_window_nxt = '0;
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end

    w_busy_nxt = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_PARITY);
  end

  assign bus.cfg_out   = r_cfg_out;
  assign bus.cfg_load  = r_load;
  assign bus.cfg_done  = r_done;
  assign bus.cfg_error = r_error;
  assign bus.busy      = r_busy;
endmodule
